piso_bit_serializer: RTL and testbench
======================================

// Module: piso_bit_serializer
// PURPOSE
//  Parallel-in/serial-out stage directly upstream of the moore1011 sequence detector.
//  Accepts WIDTH-bit words over a valid/ready handshake.
//  Emits them one bit per clk on serial_out, which drives the detector's 'in' port.
//  Optional inter-frame gap inserts idle bits between words, so detector patterns can
//  be made to span or not span word boundaries.
// PARAMETERS
//  WIDTH       8  bits per word; legal range 2..32
//  MSB_FIRST   1  1: send data_in[WIDTH-1] first; 0: send data_in[0] first
//  IDLE_BIT    0  level driven on serial_out whenever bit_valid=0
//  GAP_CYCLES  0  idle-bit cycles inserted after each word; legal range 0..15
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  data_in     in   WIDTH  parallel word; sampled only on handshake
//  load_valid  in   1      upstream has a word on data_in
//  load_ready  out  1      block accepts a word this cycle
//  serial_out  out  1      serial bit stream; connects to detector 'in'
//  bit_valid   out  1      serial_out carries a data bit this cycle
//  frame_done  out  1      1-cycle pulse coincident with the last bit of a word
//  busy        out  1      high in SHIFT or GAP
// BEHAVIOUR
//  Reset, sampled at the clk edge while rst=1:
//   state=IDLE; shift register, bit counter and gap counter=0.
//   serial_out=IDLE_BIT; bit_valid=0; frame_done=0; busy=0.
//   A reset during SHIFT or GAP abandons the word. No partial bits follow.
//  Outputs: serial_out, bit_valid, frame_done and busy are registered.
//   load_ready is combinational from state and counters only. It never depends on load_valid.
//  Handshake:
//   A word is accepted at the edge where load_valid=1 and load_ready=1.
//   data_in is copied into the shift register at that edge.
//   Later changes to data_in have no effect on the word being sent.
//   load_valid=1 while load_ready=0 is ignored: no capture and no state change.
//   Upstream holds data_in and load_valid until it sees the handshake.
//  Latency: the first bit appears on serial_out with bit_valid=1 in the cycle
//   after the accept edge.
//  FSM (states IDLE, SHIFT, GAP):
//   IDLE:  load_ready=1. Accept -> SHIFT, bit counter=0. No accept -> stay.
//   SHIFT: serial_out = current bit; bit_valid=1; busy=1.
//    Each cycle the register shifts left (MSB_FIRST=1) or right (MSB_FIRST=0).
//    The vacated bit is zero-filled.
//    Bit counter counts 0..WIDTH-1. At WIDTH-1: frame_done=1.
//    Exit from the last bit:
//     GAP_CYCLES=0: load_ready=1 during the last bit. Accept -> SHIFT with the new word,
//      giving back-to-back bits with no bubble. No accept -> IDLE.
//     GAP_CYCLES>0: -> GAP, gap counter=0.
//   GAP:   serial_out=IDLE_BIT; bit_valid=0; busy=1.
//    The gap lasts exactly GAP_CYCLES cycles.
//    load_ready=1 only in the final gap cycle. Accept -> SHIFT; no accept -> IDLE.
//  Simultaneous events: rst=1 overrides any handshake in the same cycle.
//  Width rules:
//   Bit counter is $clog2(WIDTH) bits and wraps only via reload to 0.
//   Gap counter is 4 bits.
// STRUCTURE
//  Shared package serializer_pkg:
//   typedef enum {IDLE, SHIFT, GAP} ser_state_t;
//   localparams SER_WIDTH_DEFAULT=8 and SER_GAP_MAX=15.
//  One sub-module, ser_shift_reg: WIDTH-bit loadable shifter with direction parameter.
//   Ports: clk, rst, load, shift, din, dout_bit.
//  FSM and counters stay in the top level.
// TESTING  (WIDTH=4 unless stated; cycle k = k-th clk after the accept edge)
//  1) Basic send. MSB_FIRST=1, GAP=0, single word 4'b1011.
//     -> serial_out=1,0,1,1 with bit_valid=1 on cycles 1..4; frame_done on cycle 4.
//     -> Cycle 5: IDLE_BIT, bit_valid=0.
//     -> A downstream moore1011 raises out after the final 1.
//  2) Back-to-back words. 4'b1011 then 4'b0110, load_valid held, GAP=0.
//     -> 8 consecutive bit_valid cycles: 1,0,1,1,0,1,1,0.
//     -> load_ready=1 on cycle 4 only while in SHIFT.
//  3) Inter-frame gap. GAP_CYCLES=2, words 4'b1011 and 4'b1011.
//     -> Bits, then 2 cycles of IDLE_BIT, then bits again.
//     -> load_ready=1 only on cycle 6.
//  4) LSB-first. MSB_FIRST=0, word 4'b1101.
//     -> serial_out=1,0,1,1.
//  5) Reset mid-frame. rst=1 after 2 bits of 4'b1011.
//     -> Next cycle: bit_valid=0, serial_out=IDLE_BIT, busy=0, load_ready=1.
//     -> No remaining bits are emitted.
//  6) Back-pressure. Change data_in and pulse load_valid while in SHIFT.
//     -> Current word is unchanged.
//     -> The pulse is ignored unless load_ready=1 in that cycle.

Source files
------------

// File: rtl/piso_bit_serializer_pkg.sv
// rtl/piso_bit_serializer_pkg.sv - shared state encoding, limits and helpers for the bit serializer
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  localparam int SER_WIDTH_DEFAULT = 8;
  localparam int SER_GAP_MAX       = 15;
  localparam int SER_GAP_W         = $clog2(SER_GAP_MAX + 1);

  // First bit on the line for a word of the given width and order.
  function automatic logic head_bit(input logic [31:0] word, input int width, input bit msb_first);
    return msb_first ? word[5'(width - 1)] : word[0];
  endfunction

endpackage

// File: rtl/piso_bit_serializer_if.sv
// rtl/piso_bit_serializer_if.sv - word load handshake between upstream and the serializer
interface piso_bit_serializer_if
  import serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/piso_bit_serializer_ser_shift_reg.sv
// rtl/piso_bit_serializer_ser_shift_reg.sv - loadable zero-filling shifter feeding the serial output flop
module ser_shift_reg
  import serializer_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout_bit
);

  logic [WIDTH-1:0] sreg;
  logic             unused_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    end
  end

  // The head bit is already on the line through the top's output flop, so we preview the next one.
  assign dout_bit    = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
  assign unused_head = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/piso_bit_serializer.sv
// rtl/piso_bit_serializer.sv - parallel-in/serial-out word serializer with optional inter-frame gap
module piso_bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH      = SER_WIDTH_DEFAULT,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_BIT   = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  piso_bit_serializer_if.slave   ld,
  output logic                   serial_out,
  output logic                   bit_valid,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_GAP   = GAP;

  localparam bit                   HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [CW-1:0]        LAST_BIT = CW'(WIDTH - 1);
  localparam logic [SER_GAP_W-1:0] LAST_GAP = SER_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]           state, state_nxt;
  logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [SER_GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic                 last_bit, last_gap, accept;
  logic                 first_bit, next_bit;

  assign last_bit      = (state == S_SHIFT) && (bit_cnt == LAST_BIT);
  assign last_gap      = (state == S_GAP) && (gap_cnt == LAST_GAP);
  assign ld.load_ready = (state == S_IDLE) || (last_bit && !HAS_GAP) || last_gap;
  assign accept        = ld.load_valid && ld.load_ready;
  assign first_bit     = head_bit(32'(ld.data_in), WIDTH, MSB_FIRST);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt   = S_SHIFT;
          bit_cnt_nxt = '0;
        end
      end
      S_SHIFT: begin
        if (!last_bit) begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end else if (HAS_GAP) begin
          state_nxt   = S_GAP;
          gap_cnt_nxt = '0;
        end else if (accept) begin
          bit_cnt_nxt = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (!last_gap) begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end else if (accept) begin
          state_nxt   = S_SHIFT;
          bit_cnt_nxt = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (state == S_SHIFT),
    .din      (ld.data_in),
    .dout_bit (next_bit)
  );

  // Outputs are registered from the next state so they line up with the bit being sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      serial_out <= IDLE_BIT;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      bit_valid  <= (state_nxt == S_SHIFT);
      frame_done <= (state_nxt == S_SHIFT) && (bit_cnt_nxt == LAST_BIT);
      busy       <= (state_nxt != S_IDLE);
      if (accept) begin
        serial_out <= first_bit;
      end else if (state_nxt == S_SHIFT) begin
        serial_out <= next_bit;
      end else begin
        serial_out <= IDLE_BIT;
      end
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// tb/tb_piso_bit_serializer.sv - self-checking bench for piso_bit_serializer in three configurations
module tb_piso_bit_serializer;
  import serializer_pkg::*;

  localparam int W      = 4;
  localparam int N_RAND = 1500;

  typedef struct {
    int          d;
    int          nw;
    logic [3:0]  w0;
    logic [3:0]  w1;
    int          ncyc;
    logic [15:0] valid;
    logic [15:0] bits;
    logic [15:0] done;
    logic [15:0] rdy;
    logic [15:0] bsy;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din [3];
  logic [2:0]   lv = '0;
  logic [2:0]   lr, so, bv, fd, bz;
  int           nerr = 0;
  int           nchk = 0;
  vec_t         vecs [4];

  bit ev  [3][0:N_RAND+15];
  bit eb  [3][0:N_RAND+15];
  bit ef  [3][0:N_RAND+15];
  bit ebz [3][0:N_RAND+15];
  int free_at [3];

  always #5 clk = ~clk;

  piso_bit_serializer_if #(.WIDTH(W)) if0 ();
  piso_bit_serializer_if #(.WIDTH(W)) if1 ();
  piso_bit_serializer_if #(.WIDTH(W)) if2 ();

  assign if0.data_in = din[0];
  assign if1.data_in = din[1];
  assign if2.data_in = din[2];
  assign if0.load_valid = lv[0];
  assign if1.load_valid = lv[1];
  assign if2.load_valid = lv[2];
  assign lr[0] = if0.load_ready;
  assign lr[1] = if1.load_ready;
  assign lr[2] = if2.load_ready;

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .ld(if0),
    .serial_out(so[0]), .bit_valid(bv[0]), .frame_done(fd[0]), .busy(bz[0]));
  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .ld(if1),
    .serial_out(so[1]), .bit_valid(bv[1]), .frame_done(fd[1]), .busy(bz[1]));
  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .GAP_CYCLES(0)) u2 (
    .clk(clk), .rst(rst), .ld(if2),
    .serial_out(so[2]), .bit_valid(bv[2]), .frame_done(fd[2]), .busy(bz[2]));

  function automatic int gap_of(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  function automatic bit msb_of(input int d);
    return (d != 2);
  endfunction

  task automatic chk(input string nm, input int d, input int k, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d k=%0d: got %b want %b", nm, d, k, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   sent;
    logic acc;
    sent = 0;
    @(negedge clk);
    din[v.d] = v.w0;
    lv[v.d]  = 1'b1;
    acc      = lv[v.d] & lr[v.d];
    for (int k = 1; k <= v.ncyc; k++) begin
      @(negedge clk);
      if (acc) begin
        sent++;
        if (sent < v.nw) din[v.d] = v.w1;
        else             lv[v.d]  = 1'b0;
      end
      chk("vec_valid", v.d, k, bv[v.d], v.valid[k]);
      chk("vec_serial", v.d, k, so[v.d], v.bits[k]);
      chk("vec_done", v.d, k, fd[v.d], v.done[k]);
      chk("vec_ready", v.d, k, lr[v.d], v.rdy[k]);
      chk("vec_busy", v.d, k, bz[v.d], v.bsy[k]);
      acc = lv[v.d] & lr[v.d];
    end
    lv[v.d] = 1'b0;
  endtask

  initial begin
    logic [7:0] bp_stream;
    for (int d = 0; d < 3; d++) din[d] = '0;

    vecs[0] = '{0, 1, 4'b1011, 4'b0000, 6,  16'h001E, 16'h001A, 16'h0010, 16'h0070, 16'h001E};
    vecs[1] = '{0, 2, 4'b1011, 4'b0110, 10, 16'h01FE, 16'h00DA, 16'h0110, 16'h0710, 16'h01FE};
    vecs[2] = '{1, 2, 4'b1011, 4'b1011, 14, 16'h079E, 16'h069A, 16'h0410, 16'h7040, 16'h1FFE};
    vecs[3] = '{2, 1, 4'b1101, 4'b0000, 6,  16'h001E, 16'h001A, 16'h0010, 16'h0070, 16'h001E};

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", d, 0, bv[d], 1'b0);
      chk("rst_serial", d, 0, so[d], 1'b0);
      chk("rst_done", d, 0, fd[d], 1'b0);
      chk("rst_busy", d, 0, bz[d], 1'b0);
      chk("rst_ready", d, 0, lr[d], 1'b1);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i]);
      repeat (2) @(negedge clk);
    end

    // Reset two bits into a word on dut0, with a competing handshake on idle dut2.
    din[0] = 4'b1011;
    lv[0]  = 1'b1;
    @(negedge clk);
    lv[0] = 1'b0;
    chk("mid_rst_bit1", 0, 1, so[0], 1'b1);
    @(negedge clk);
    chk("mid_rst_bit2", 0, 2, so[0], 1'b0);
    chk("mid_rst_valid2", 0, 2, bv[0], 1'b1);
    rst    = 1'b1;
    din[2] = 4'b1111;
    lv[2]  = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    lv[2] = 1'b0;
    chk("mid_rst_valid", 0, 3, bv[0], 1'b0);
    chk("mid_rst_serial", 0, 3, so[0], 1'b0);
    chk("mid_rst_busy", 0, 3, bz[0], 1'b0);
    chk("mid_rst_ready", 0, 3, lr[0], 1'b1);
    chk("rst_over_hs_busy", 2, 3, bz[2], 1'b0);
    for (int k = 4; k < 8; k++) begin
      @(negedge clk);
      chk("mid_rst_quiet", 0, k, bv[0], 1'b0);
      chk("rst_over_hs_quiet", 2, k, bv[2], 1'b0);
    end

    // Back-pressure: a pulse while not ready is dropped, a pulse at the ready cycle is taken.
    bp_stream = 8'b1011_0100;
    din[0] = 4'b1011;
    lv[0]  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("bp_valid", 0, k, bv[0], (k <= 8));
      chk("bp_serial", 0, k, so[0], (k <= 8) ? bp_stream[8-k] : 1'b0);
      case (k)
        2: begin
          din[0] = 4'b0000;
          lv[0]  = 1'b1;
          chk("bp_ready_busy", 0, k, lr[0], 1'b0);
        end
        3: begin
          din[0] = 4'b0100;
          lv[0]  = 1'b0;
        end
        4: begin
          lv[0] = 1'b1;
          chk("bp_ready_last", 0, k, lr[0], 1'b1);
        end
        default: lv[0] = 1'b0;
      endcase
    end
    repeat (2) @(negedge clk);

    // Randomised traffic against a schedule-based reference.
    for (int d = 0; d < 3; d++) free_at[d] = 0;
    for (int c = 0; c < N_RAND; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk("rnd_ready", d, c, lr[d], (c >= free_at[d]));
        chk("rnd_valid", d, c, bv[d], ev[d][c]);
        chk("rnd_serial", d, c, so[d], eb[d][c]);
        chk("rnd_done", d, c, fd[d], ef[d][c]);
        chk("rnd_busy", d, c, bz[d], ebz[d][c]);
      end
      rst = ($urandom_range(0, 149) == 0);
      for (int d = 0; d < 3; d++) begin
        lv[d]  = ($urandom_range(0, 3) != 0);
        din[d] = 4'($urandom);
      end
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          for (int j = c + 1; j <= c + W + 2; j++) begin
            ev[d][j]  = 1'b0;
            eb[d][j]  = 1'b0;
            ef[d][j]  = 1'b0;
            ebz[d][j] = 1'b0;
          end
          free_at[d] = c + 1;
        end else if (lv[d] && (c >= free_at[d])) begin
          for (int k = 1; k <= W; k++) begin
            ev[d][c+k] = 1'b1;
            eb[d][c+k] = msb_of(d) ? din[d][W-k] : din[d][k-1];
          end
          ef[d][c+W] = 1'b1;
          for (int k = 1; k <= W + gap_of(d); k++) ebz[d][c+k] = 1'b1;
          free_at[d] = c + W + gap_of(d);
        end
      end
    end
    rst = 1'b0;
    lv  = '0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
